// File: rtl/fft_seq_pkg.sv
// ---------------------------------------------------------------------------
// fft_seq_pkg
// Shared definitions for the radix-2 DIT FFT stage sequencer:
//   - seq_state_e : FSM state encoding (IDLE, RUN, DRAIN, DONE)
//   - N_LOG2_MIN  : smallest accepted transform size as log2(N)
//   - N_LOG2_MAX  : largest transform size the architecture supports
//   - n_log2_ok() : range check applied when a start request is accepted
// ---------------------------------------------------------------------------
package fft_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [3:0] N_LOG2_MIN = 4'd2;
    localparam logic [3:0] N_LOG2_MAX = 4'd10;

    // True when n lies in [N_LOG2_MIN, min(limit, N_LOG2_MAX)].
    function automatic logic n_log2_ok(input logic [3:0] n, input logic [3:0] limit);
        return (n >= N_LOG2_MIN) && (n <= limit) && (n <= N_LOG2_MAX);
    endfunction

endpackage

// File: rtl/fft_seq_delay.sv
// ---------------------------------------------------------------------------
// fft_seq_delay
// Fixed-depth shift register that carries {valid, addr_a, addr_b} from the
// butterfly read side to the write-back side. DEPTH equals the butterfly
// pipeline latency, so an entry appears at dout exactly DEPTH enabled edges
// after it was presented at din.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset, clears every stage
//   en   : shift enable; when low the whole line holds
//   din  : entry entering the line
//   dout : entry leaving the line (registered)
// ---------------------------------------------------------------------------
module fft_seq_delay #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // Next contents of the line: shift by one when enabled, otherwise hold.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (en) begin
            pipe_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end else begin
            pipe_d[0] = pipe_q[0];
        end
    end

    // Line storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
// Address sequencer for an in-place, ping-pong-banked radix-2 DIT FFT.
// For each stage s it issues N/2 butterflies (one per cycle), then drains the
// butterfly pipeline for BF_LATENCY cycles so the last write of a stage lands
// before the first read of the next. Write-back addresses are the read
// addresses delayed by BF_LATENCY through fft_seq_delay.
//
// Optional feature (macro FFT_SEQ_STALL_EN): adds input 'stall'. While stall
// is high the FSM, counters and delay line hold and bf_valid / wr_en / done
// are forced low; every stalled cycle lengthens the run by one cycle.
//
// Ports:
//   clk         : sole clock, rising edge
//   rst         : synchronous active-low reset
//   start       : one-cycle start request, honoured only in IDLE
//   n_log2      : log2(N), sampled with start
//   stall       : (FFT_SEQ_STALL_EN only) freeze request
//   rd_addr_a/b : butterfly operand read addresses
//   tw_addr     : twiddle ROM index
//   bf_valid    : read/twiddle addresses valid this cycle
//   wr_addr_a/b : write-back addresses (read addresses delayed)
//   wr_en       : write-back strobe (bf_valid delayed)
//   rd_bank     : bank read in the current stage; write bank is ~rd_bank
//   result_bank : bank holding the final result after done
//   stage       : current stage index
//   busy        : high from start acceptance until done
//   done        : one-cycle completion pulse
//   error       : sticky flag for a rejected n_log2
// ---------------------------------------------------------------------------
module fft_stage_sequencer
    import fft_seq_pkg::*;
#(
    parameter int MAX_N      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BF_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [3:0]            n_log2,
`ifdef FFT_SEQ_STALL_EN
    input  logic                  stall,
`endif
    output logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [ADDR_WIDTH-2:0] tw_addr,
    output logic                  bf_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr_a,
    output logic [ADDR_WIDTH-1:0] wr_addr_b,
    output logic                  wr_en,
    output logic                  rd_bank,
    output logic                  result_bank,
    output logic [3:0]            stage,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int         AW     = ADDR_WIDTH;
    localparam int         KW     = ADDR_WIDTH - 1;
    localparam int         DLY_W  = 1 + 2 * ADDR_WIDTH;
    localparam logic [3:0] L_MAX  = 4'($clog2(MAX_N));
    localparam logic [1:0] D_LAST = 2'(BF_LATENCY - 1);

    // Control state
    seq_state_e     state_q, state_d;
    logic [3:0]     s_q, s_d;
    logic [KW-1:0]  k_q, k_d;
    logic [3:0]     l_q, l_d;
    logic [1:0]     d_q, d_d;
    logic           error_q, error_d;
    logic           result_bank_q, result_bank_d;

    // Registered outputs
    logic           bf_valid_q, bf_valid_d;
    logic [AW-1:0]  rd_addr_a_q, rd_addr_a_d;
    logic [AW-1:0]  rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0]  tw_addr_q, tw_addr_d;
    logic           rd_bank_q, rd_bank_d;
    logic [3:0]     stage_q, stage_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Combinational helpers
    logic           hold;
    logic [KW-1:0]  last_k;
    logic [AW-1:0]  k_ext;
    logic [AW-1:0]  half;
    logic [AW-1:0]  mask;
    logic [AW-1:0]  addr_a;
    logic [DLY_W-1:0] dly_in;
    logic [DLY_W-1:0] dly_out;

`ifdef FFT_SEQ_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Index of the final butterfly of a stage: N/2 - 1 for the latched size.
    assign last_k = KW'((AW'(1) << (l_q - 4'd1)) - AW'(1));

    // FSM and counter next-state; everything holds while frozen.
    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        k_d           = k_q;
        l_d           = l_q;
        d_d           = d_q;
        error_d       = error_q;
        result_bank_d = result_bank_q;
        if (hold) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (n_log2_ok(n_log2, L_MAX)) begin
                            state_d       = ST_RUN;
                            s_d           = 4'd0;
                            k_d           = {KW{1'b0}};
                            l_d           = n_log2;
                            error_d       = 1'b0;
                            // Input sits in bank 1 and banks swap each stage.
                            result_bank_d = ~n_log2[0];
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (k_q == last_k) begin
                        state_d = ST_DRAIN;
                        d_d     = 2'd0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (d_q == D_LAST) begin
                        if (s_q == (l_q - 4'd1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                            s_d     = s_q + 4'd1;
                            k_d     = {KW{1'b0}};
                        end
                    end else begin
                        d_d = d_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Radix-2 DIT addressing for the butterfly selected by the next state:
    // a inserts a zero at bit s of k, b sets that bit, and the twiddle index
    // is the low s bits of k scaled to the N/2-entry ROM.
    always_comb begin
        k_ext  = {1'b0, k_d};
        half   = AW'(1) << s_d;
        mask   = half - AW'(1);
        addr_a = ((k_ext >> s_d) << (s_d + 4'd1)) | (k_ext & mask);

        busy_d     = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        bf_valid_d = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);

        if (bf_valid_d) begin
            rd_addr_a_d = addr_a;
            rd_addr_b_d = addr_a + half;
            tw_addr_d   = KW'((k_ext & mask) << (l_d - 4'd1 - s_d));
        end else begin
            rd_addr_a_d = {AW{1'b0}};
            rd_addr_b_d = {AW{1'b0}};
            tw_addr_d   = {KW{1'b0}};
        end

        if (busy_d) begin
            stage_d   = s_d;
            rd_bank_d = ~s_d[0];
        end else begin
            stage_d   = 4'd0;
            rd_bank_d = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            s_q           <= 4'd0;
            k_q           <= {KW{1'b0}};
            l_q           <= 4'd0;
            d_q           <= 2'd0;
            error_q       <= 1'b0;
            result_bank_q <= 1'b0;
            bf_valid_q    <= 1'b0;
            rd_addr_a_q   <= {AW{1'b0}};
            rd_addr_b_q   <= {AW{1'b0}};
            tw_addr_q     <= {KW{1'b0}};
            rd_bank_q     <= 1'b0;
            stage_q       <= 4'd0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            s_q           <= s_d;
            k_q           <= k_d;
            l_q           <= l_d;
            d_q           <= d_d;
            error_q       <= error_d;
            result_bank_q <= result_bank_d;
            bf_valid_q    <= bf_valid_d;
            rd_addr_a_q   <= rd_addr_a_d;
            rd_addr_b_q   <= rd_addr_b_d;
            tw_addr_q     <= tw_addr_d;
            rd_bank_q     <= rd_bank_d;
            stage_q       <= stage_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Write-back path: issued butterflies re-emerge BF_LATENCY edges later.
    assign dly_in = {bf_valid_q, rd_addr_a_q, rd_addr_b_q};

    fft_seq_delay #(
        .DEPTH (BF_LATENCY),
        .WIDTH (DLY_W)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .en   (~hold),
        .din  (dly_in),
        .dout (dly_out)
    );

    // Strobes are masked while frozen; the held entry is emitted once the
    // freeze lifts, so nothing is lost or duplicated.
    assign bf_valid    = bf_valid_q & ~hold;
    assign wr_en       = dly_out[DLY_W-1] & ~hold;
    assign done        = done_q & ~hold;
    assign wr_addr_a   = dly_out[2*AW-1:AW];
    assign wr_addr_b   = dly_out[AW-1:0];
    assign rd_addr_a   = rd_addr_a_q;
    assign rd_addr_b   = rd_addr_b_q;
    assign tw_addr     = tw_addr_q;
    assign rd_bank     = rd_bank_q;
    assign result_bank = result_bank_q;
    assign stage       = stage_q;
    assign busy        = busy_q;
    assign error       = error_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_sequencer
// Directed bench for fft_stage_sequencer with N=8, BF_LATENCY=2. Expected
// read/twiddle sequences are hand-computed tables; write-back is checked
// against a queue of issued butterflies. Cycle numbering: the start edge is
// cycle 1, so done is expected at cycle L*(N/2+BF_LATENCY)+1 = 19.
// Build with FFT_SEQ_STALL_EN defined to add the stall scenario.
// ---------------------------------------------------------------------------
module tb_fft_stage_sequencer;

    localparam int MAX_N = 8;
    localparam int AW    = 3;
    localparam int BF    = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [3:0]    n_log2;
`ifdef FFT_SEQ_STALL_EN
    logic          stall;
`endif
    logic [AW-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [AW-2:0] tw_addr;
    logic          bf_valid, wr_en, rd_bank, result_bank, busy, done, error;
    logic [3:0]    stage;

    fft_stage_sequencer #(
        .MAX_N      (MAX_N),
        .ADDR_WIDTH (AW),
        .BF_LATENCY (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .n_log2      (n_log2),
`ifdef FFT_SEQ_STALL_EN
        .stall       (stall),
`endif
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .tw_addr     (tw_addr),
        .bf_valid    (bf_valid),
        .wr_addr_a   (wr_addr_a),
        .wr_addr_b   (wr_addr_b),
        .wr_en       (wr_en),
        .rd_bank     (rd_bank),
        .result_bank (result_bank),
        .stage       (stage),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    // Hand-computed N=8 issue order: stages 0,1,2 with four butterflies each.
    int exp_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int exp_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int exp_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    typedef struct {
        int c;
        int a;
        int b;
    } iss_t;

    iss_t iss_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   t0       = 0;
    int   rd_cnt   = 0;
    int   wr_cnt   = 0;
    int   done_cnt = 0;
    int   done_rel = 0;
    bit   mon_en   = 1'b0;
    bit   chk_lat  = 1'b1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        done_rel = 0;
        iss_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_bf_valid"}, int'(bf_valid), 0);
        check_eq({tag, "_wr_en"}, int'(wr_en), 0);
        check_eq({tag, "_busy"}, int'(busy), 0);
        check_eq({tag, "_done"}, int'(done), 0);
        check_eq({tag, "_error"}, int'(error), 0);
        check_eq({tag, "_stage"}, int'(stage), 0);
        check_eq({tag, "_banks"}, int'({rd_bank, result_bank}), 0);
        check_eq({tag, "_addrs"}, int'({rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b}), 0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: checks reads against the tables and writes against the queue.
    initial begin
        iss_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wr_en) begin
                    if (iss_q.size() == 0) begin
                        check_eq("wr_orphan", 1, 0);
                    end else begin
                        e = iss_q.pop_front();
                        if (chk_lat) check_eq("wr_latency", cyc - e.c, BF);
                        check_eq("wr_addr_a", int'(wr_addr_a), e.a);
                        check_eq("wr_addr_b", int'(wr_addr_b), e.b);
                    end
                    wr_cnt++;
                end
                if (bf_valid) begin
                    if (rd_cnt < 12) begin
                        check_eq("rd_addr_a", int'(rd_addr_a), exp_a[rd_cnt]);
                        check_eq("rd_addr_b", int'(rd_addr_b), exp_b[rd_cnt]);
                        check_eq("tw_addr", int'(tw_addr), exp_tw[rd_cnt]);
                        check_eq("stage", int'(stage), rd_cnt / 4);
                        check_eq("rd_bank", int'(rd_bank), ((rd_cnt / 4) % 2 == 0) ? 1 : 0);
                        // Every write of earlier stages must already be done.
                        if (rd_cnt >= 4) check_eq("rd_after_wr", int'(wr_cnt >= (rd_cnt / 4) * 4), 1);
                    end else begin
                        check_eq("rd_extra", rd_cnt, 11);
                    end
                    e.c = cyc;
                    e.a = int'(rd_addr_a);
                    e.b = int'(rd_addr_b);
                    iss_q.push_back(e);
                    rd_cnt++;
                end
                if (done) begin
                    done_cnt++;
                    done_rel = cyc - t0 + 1;
                end
            end
        end
    end

    // Pulse start with the given size; leaves time just after the start edge.
    task automatic pulse_start(input logic [3:0] n);
        @(posedge clk);
        #1;
        n_log2 = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
    endtask

    // Full N=8 run with optional start-while-busy and a 3-cycle stall.
    task automatic run_n8(input string tag, input bit mid_start, input bit do_stall, input int exp_done);
        int rel;
        clear_mon();
        chk_lat = !do_stall;
        pulse_start(4'd3);
        rel = 1;
        check_eq({tag, "_busy_hi"}, int'(busy), 1);
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            start  = mid_start && (rel == 4);
            n_log2 = (mid_start && rel == 4) ? 4'd2 : 4'd3;
`ifdef FFT_SEQ_STALL_EN
            stall  = do_stall && (rel >= 3) && (rel <= 5);
`endif
            @(posedge clk);
            #1;
            rel = cyc - t0 + 1;
        end
        start = 1'b0;
`ifdef FFT_SEQ_STALL_EN
        stall = 1'b0;
`endif
        check_eq({tag, "_done_seen"}, done_cnt, 1);
        check_eq({tag, "_done_cycle"}, done_rel, exp_done);
        check_eq({tag, "_reads"}, rd_cnt, 12);
        check_eq({tag, "_writes"}, wr_cnt, 12);
        check_eq({tag, "_result_bank"}, int'(result_bank), 0);
        check_eq({tag, "_busy_lo"}, int'(busy), 0);
        check_eq({tag, "_error"}, int'(error), 0);
        check_eq({tag, "_done_pulse"}, int'(done), 0);
        chk_lat = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        n_log2 = 4'd0;
`ifdef FFT_SEQ_STALL_EN
        stall  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst    = 1'b1;
        mon_en = 1'b1;

        // Basic transform.
        run_n8("base", 1'b0, 1'b0, 19);

        // Rejected sizes: error set, nothing issued, then cleared by valid start.
        clear_mon();
        pulse_start(4'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("n0_error", int'(error), 1);
        check_eq("n0_busy", int'(busy), 0);
        check_eq("n0_reads", rd_cnt, 0);
        pulse_start(4'd4);
        repeat (3) @(posedge clk);
        #1;
        check_eq("n4_error", int'(error), 1);
        check_eq("n4_busy", int'(busy), 0);
        check_eq("n4_reads", rd_cnt, 0);
        run_n8("after_err", 1'b0, 1'b0, 19);

        // Start while busy has no effect.
        run_n8("mid_start", 1'b1, 1'b0, 19);

        // Reset sampled at cycle 8 of a run.
        clear_mon();
        pulse_start(4'd3);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        rst = 1'b1;
        begin
            int snap;
            snap = wr_cnt;
            repeat (10) @(posedge clk);
            #1;
            check_eq("midrst_no_wr", wr_cnt, snap);
            check_eq("midrst_idle", int'(busy), 0);
        end
        run_n8("post_rst", 1'b0, 1'b0, 19);

`ifdef FFT_SEQ_STALL_EN
        run_n8("stall", 1'b0, 1'b1, 22);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
